// File: rtl/sram_fifo_arbiter.sv
// Two-writer round-robin arbiter feeding a FIFO whose storage is an external
// dual-port SRAM with one cycle of registered read latency.
module sram_fifo_arbiter #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 wr0_req,
  input  logic [DATA_BITS-1:0] wr0_data,
  output logic                 wr0_ack,
  input  logic                 wr1_req,
  input  logic [DATA_BITS-1:0] wr1_data,
  output logic                 wr1_ack,
  input  logic                 rd_req,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 sram_write_en,
  output logic [ADDR_BITS-1:0] sram_write_addr,
  output logic [DATA_BITS-1:0] sram_write_data,
  output logic [ADDR_BITS-1:0] sram_read_addr,
  input  logic [DATA_BITS-1:0] sram_read_data,
  output logic [ADDR_BITS:0]   count,
  output logic                 full,
  output logic                 empty
);

  typedef enum logic {
    LAST_WR0 = 1'b0,
    LAST_WR1 = 1'b1
  } last_grant_t;

  localparam logic [ADDR_BITS:0] DEPTH = {1'b1, {ADDR_BITS{1'b0}}};

  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [ADDR_BITS:0]   count_q;
  logic                 rd_valid_q;
  last_grant_t          last_grant;
  logic                 grant0;
  logic                 grant1;
  logic                 grant;
  logic                 pop;

  assign full  = (count_q == DEPTH);
  assign empty = (count_q == '0);
  assign count = count_q;

  // Contention goes to whichever writer was not served most recently.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!full && !flush) begin
      if (wr0_req && wr1_req) begin
        if (last_grant == LAST_WR1) grant0 = 1'b1;
        else                        grant1 = 1'b1;
      end else begin
        grant0 = wr0_req;
        grant1 = wr1_req;
      end
    end
  end

  assign grant = grant0 | grant1;
  assign pop   = rd_req && !empty && !flush;

  assign wr0_ack         = grant0;
  assign wr1_ack         = grant1;
  assign sram_write_en   = grant;
  assign sram_write_addr = wr_ptr;
  assign sram_write_data = grant1 ? wr1_data : wr0_data;
  assign sram_read_addr  = rd_ptr;
  assign rd_valid        = rd_valid_q;
  assign rd_data         = sram_read_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      last_grant <= LAST_WR1;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= pop;
      if (grant) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (grant0)      last_grant <= LAST_WR0;
      else if (grant1) last_grant <= LAST_WR1;
      // A simultaneous push and pop leaves the occupancy unchanged.
      case ({grant, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
